// File: rtl/spram_frame_ctrl_if.sv
// Port bundle for spram_frame_ctrl: input stream, output stream and RAM port.
// master = controller side; slave = source, sink and RAM side.
interface spram_frame_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_douta;

  modport master (
    input  s_valid, s_data, s_last, m_ready, ram_douta,
    output s_ready, m_valid, m_data, m_last, ram_wea, ram_addra, ram_dina
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, ram_douta,
    input  s_ready, m_valid, m_data, m_last, ram_wea, ram_addra, ram_dina
  );
endinterface

// File: rtl/spram_frame_ctrl.sv
// Single-frame fill/drain controller in front of a registered-address single-port RAM.
// Optional sticky truncation flag: define SPRAM_FRAME_TRUNC_FLAG_EN.
//
// state | meaning
// FILL  | accepting input words, writing RAM at wr_ptr
// PRIME | one-cycle gap loading RAM address 0 for the read latency
// DRAIN | presenting RAM output downstream, rd_ptr tracks the visible word
module spram_frame_ctrl #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic               clka,
  input  logic               rsta,
  spram_frame_ctrl_if.master bus,
  output logic               trunc
);
  localparam logic [1:0]    FILL    = 2'd0;
  localparam logic [1:0]    PRIME   = 2'd1;
  localparam logic [1:0]    DRAIN   = 2'd2;
  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] last_idx_q, last_idx_d;
  logic [AW-1:0] addr_d;
  logic          fill_hs, frame_end, drain_hs, is_last;

  assign fill_hs   = (state_q == FILL) && bus.s_valid && !rsta;
  assign frame_end = fill_hs && (bus.s_last || (wr_ptr_q == PTR_MAX));
  assign drain_hs  = (state_q == DRAIN) && bus.m_ready && !rsta;
  assign is_last   = (rd_ptr_q == last_idx_q);

  assign bus.s_ready   = (state_q == FILL) && !rsta;
  assign bus.m_valid   = (state_q == DRAIN) && !rsta;
  assign bus.m_last    = bus.m_valid && is_last;
  assign bus.m_data    = bus.ram_douta;
  assign bus.ram_dina  = bus.s_data;
  assign bus.ram_wea   = fill_hs;
  assign bus.ram_addra = addr_d;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_idx_d = last_idx_q;
    addr_d     = '0;
    case (state_q)
      FILL: begin
        addr_d = wr_ptr_q;
        if (fill_hs) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (frame_end) begin
            last_idx_d = wr_ptr_q;
            wr_ptr_d   = '0;
            state_d    = PRIME;
          end
        end
      end
      PRIME: begin
        rd_ptr_d = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        // Look one word ahead only when the current word is consumed, so a stall holds ram_douta.
        addr_d = drain_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (drain_hs) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (is_last) begin
            rd_ptr_d = '0;
            state_d  = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
    if (rsta) addr_d = '0;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_idx_q <= last_idx_d;
    end
  end

`ifdef SPRAM_FRAME_TRUNC_FLAG_EN
  logic trunc_q, trunc_d;

  assign trunc_d = trunc_q | (frame_end && !bus.s_last);

  always_ff @(posedge clka) begin
    if (rsta) trunc_q <= 1'b0;
    else      trunc_q <= trunc_d;
  end

  assign trunc = trunc_q;
`else
  assign trunc = 1'b0;
`endif

endmodule

// File: tb/tb_spram_frame_ctrl.sv
// Bench for spram_frame_ctrl (AW=3): RAM model, frame-level reference model and directed/random frames.
module tb_spram_frame_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int M_FILL = 0, M_GAP = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trunc;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spram_frame_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  spram_frame_ctrl #(.DW(DW), .AW(AW)) dut (
    .clka  (clk),
    .rsta  (rst),
    .bus   (bus.master),
    .trunc (trunc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: address registered on the clock, read combinationally from the array
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_aq;
  always @(posedge clk) begin
    ram_aq <= bus.ram_addra;
    if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
  end
  assign bus.ram_douta = mem[ram_aq];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // reference model state
  int            mode = M_FILL;
  logic [DW-1:0] frame[$];
  int            oi = 0;
  bit            exp_trunc = 0;
  int            last_in_cyc = 0;
  logic [DW-1:0] out_log[$];
  bit            out_last[$];
  int            out_cyc[$];
  int            wea_outside_fill = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_last", bus.m_last, 0);
      chk("rst_wea", bus.ram_wea, 0);
      chk("rst_addra", bus.ram_addra, 0);
      mode = M_FILL;
      frame.delete();
      oi = 0;
      exp_trunc = 0;
    end else begin
      chk("trunc", trunc, exp_trunc);
      if (mode != M_FILL && bus.ram_wea) wea_outside_fill++;
      case (mode)
        M_FILL: begin
          chk("fill_s_ready", bus.s_ready, 1);
          chk("fill_m_valid", bus.m_valid, 0);
          chk("fill_m_last", bus.m_last, 0);
          chk("fill_wea", bus.ram_wea, bus.s_valid);
          chk("fill_addra", bus.ram_addra, frame.size() % DEPTH);
          if (bus.s_valid) begin
            chk("fill_dina", bus.ram_dina, bus.s_data);
            frame.push_back(bus.s_data);
            last_in_cyc = cyc;
            if (bus.s_last || frame.size() == DEPTH) begin
`ifdef SPRAM_FRAME_TRUNC_FLAG_EN
              if (!bus.s_last) exp_trunc = 1;
`endif
              mode = M_GAP;
            end
          end
        end
        M_GAP: begin
          chk("prime_s_ready", bus.s_ready, 0);
          chk("prime_m_valid", bus.m_valid, 0);
          chk("prime_wea", bus.ram_wea, 0);
          chk("prime_addra", bus.ram_addra, 0);
          mode = M_DRAIN;
          oi = 0;
        end
        default: begin
          chk("drain_s_ready", bus.s_ready, 0);
          chk("drain_m_valid", bus.m_valid, 1);
          chk("drain_wea", bus.ram_wea, 0);
          chk("drain_m_data", bus.m_data, frame[oi]);
          chk("drain_m_last", bus.m_last, (oi == frame.size() - 1));
          chk("drain_addra", bus.ram_addra, bus.m_ready ? (oi + 1) % DEPTH : oi);
          if (bus.m_ready) begin
            out_log.push_back(bus.m_data);
            out_last.push_back(bus.m_last);
            out_cyc.push_back(cyc);
            oi++;
            if (oi == frame.size()) begin
              mode = M_FILL;
              frame.delete();
            end
          end
        end
      endcase
    end
  end

  logic [DW-1:0] stim[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.s_valid = 1'b0;
          step();
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = stim[i];
      bus.s_last  = with_last && (i == n - 1);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic drain(input int rmode, input bit junk);
    int  k = 0;
    bit  done = 0;
    bus.s_valid = junk;
    bus.s_data  = 8'hFF;
    bus.s_last  = 1'b0;
    while (!done && k < 200) begin
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (k % 3 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (bus.m_valid && bus.m_ready && bus.m_last) done = 1;
      step();
      k++;
    end
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d actual=no_last expected=last_handshake", cyc);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_last.delete();
    out_cyc.delete();
  endtask

  initial begin
    int n;
    bit wl;
    bus.s_valid = 0;
    bus.s_data  = '0;
    bus.s_last  = 0;
    bus.m_ready = 0;
    repeat (3) step();
    rst = 0;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1);

    // 5-word frame, full throughput
    stim = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    clear_logs();
    send_frame(5, 1, 0);
    drain(0, 0);
    chk("t1_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      chk("t1_data", out_log[i], 8'h11 + i);
      chk("t1_last", out_last[i], i == 4);
    end
    if (out_cyc.size() == 5) begin
      chk("t1_latency", out_cyc[0] - last_in_cyc, 2);
      chk("t1_back_to_back", out_cyc[4] - out_cyc[0], 4);
    end
    chk("t1_s_ready_after", bus.s_ready, 1);

    // same frame with stalls
    clear_logs();
    send_frame(5, 1, 0);
    drain(1, 0);
    chk("t2_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) chk("t2_data", out_log[i], 8'h11 + i);

    // full buffer, no s_last
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    clear_logs();
    send_frame(8, 0, 0);
    drain(0, 0);
    chk("t3_count", out_log.size(), 8);
    if (out_log.size() == 8) begin
      chk("t3_last_word", out_log[7], 8'hA7);
      chk("t3_last_flag", out_last[7], 1);
      chk("t3_no_early_last", out_last[6], 0);
    end
`ifdef SPRAM_FRAME_TRUNC_FLAG_EN
    chk("t3_trunc", trunc, 1);
`else
    chk("t3_trunc", trunc, 0);
`endif

    // 1-word frame
    stim = '{8'h5A};
    clear_logs();
    send_frame(1, 1, 0);
    drain(0, 0);
    chk("t4_count", out_log.size(), 1);
    if (out_log.size() == 1) begin
      chk("t4_data", out_log[0], 8'h5A);
      chk("t4_last", out_last[0], 1);
    end
    chk("t4_fill_after", bus.s_ready, 1);

    // reset mid-fill discards the partial frame
    stim = '{8'h31, 8'h32, 8'h33};
    send_frame(3, 0, 0);
    rst = 1;
    step();
    rst = 0;
    stim = '{8'h01, 8'h02};
    clear_logs();
    send_frame(2, 1, 0);
    drain(0, 0);
    chk("t5_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t5_data0", out_log[0], 8'h01);
      chk("t5_data1", out_log[1], 8'h02);
      chk("t5_last0", out_last[0], 0);
      chk("t5_last1", out_last[1], 1);
    end
    chk("t5_trunc", trunc, 0);

    // s_valid with junk during prime/drain
    stim = '{8'h21, 8'h22, 8'h23};
    clear_logs();
    wea_outside_fill = 0;
    send_frame(3, 1, 0);
    drain(1, 1);
    chk("t6_count", out_log.size(), 3);
    for (int i = 0; i < out_log.size(); i++) chk("t6_no_ff", out_log[i] == 8'hFF, 0);
    chk("t6_wea_outside_fill", wea_outside_fill, 0);

    // random frames, lengths, gaps and backpressure
    for (int f = 0; f < 25; f++) begin
      n  = $urandom_range(1, DEPTH);
      wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      clear_logs();
      send_frame(n, wl, 1);
      drain(2, 1'($urandom_range(0, 1)));
      chk("rnd_count", out_log.size(), n);
    end

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
